// File: rtl/video_driver_if.sv
// Pixel-side bundle of the video timing generator: request/return path to the
// drawing stage and the aligned sync/DE/RGB path to the encoder.
interface video_driver_if;
    logic [23:0] pixel_data;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic        data_req;
    logic        video_hs;
    logic        video_vs;
    logic        video_de;
    logic [23:0] video_rgb;
    logic        frame_start;

    modport master (
        input  pixel_data,
        output pixel_xpos, pixel_ypos, data_req,
        output video_hs, video_vs, video_de, video_rgb, frame_start
    );

    modport slave (
        output pixel_data,
        input  pixel_xpos, pixel_ypos, data_req,
        input  video_hs, video_vs, video_de, video_rgb, frame_start
    );
endinterface

// File: rtl/video_driver.sv
// Video timing generator: free-running h/v counters, combinational pixel request,
// and a one-cycle output stage aligned with the drawing stage's registered pixel_data.
module video_driver #(
    parameter logic [10:0] H_SYNC   = 11'd40,
    parameter logic [10:0] H_BACK   = 11'd220,
    parameter logic [10:0] H_DISP   = 11'd1280,
    parameter logic [10:0] H_FRONT  = 11'd110,
    parameter logic [10:0] V_SYNC   = 11'd5,
    parameter logic [10:0] V_BACK   = 11'd20,
    parameter logic [10:0] V_DISP   = 11'd720,
    parameter logic [10:0] V_FRONT  = 11'd5,
    parameter logic        SYNC_POL = 1'b1
) (
    input  logic           pixel_clk,
    input  logic           sys_rst_n,
    video_driver_if.master vid
);

    localparam logic [10:0] H_TOTAL   = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam logic [10:0] V_TOTAL   = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam logic [10:0] H_ACT     = H_SYNC + H_BACK;
    localparam logic [10:0] V_ACT     = V_SYNC + V_BACK;
    localparam logic [10:0] H_ACT_END = H_ACT + H_DISP;
    localparam logic [10:0] V_ACT_END = V_ACT + V_DISP;

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic        fs_q, fs_d;
    logic        h_last;
    logic        h_vis;
    logic        v_vis;
    logic        req;

    always_comb begin
        h_last  = (h_cnt_q == H_TOTAL - 11'd1);
        h_cnt_d = h_last ? '0 : h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = (v_cnt_q == V_TOTAL - 11'd1) ? '0 : v_cnt_q + 11'd1;
        end
    end

    always_comb begin
        h_vis = (h_cnt_q >= H_ACT) && (h_cnt_q < H_ACT_END);
        v_vis = (v_cnt_q >= V_ACT) && (v_cnt_q < V_ACT_END);
        req   = h_vis && v_vis;
    end

    // Output stage samples the current counters so it lines up with pixel_data,
    // which the drawing stage registers from this cycle's request.
    always_comb begin
        hs_d = (h_cnt_q < H_SYNC) ? SYNC_POL : ~SYNC_POL;
        vs_d = (v_cnt_q < V_SYNC) ? SYNC_POL : ~SYNC_POL;
        de_d = req;
        fs_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
        end
    end

    assign vid.data_req    = req;
    assign vid.pixel_xpos  = req ? h_cnt_q - H_ACT : '0;
    assign vid.pixel_ypos  = req ? v_cnt_q - V_ACT : '0;
    assign vid.video_hs    = hs_q;
    assign vid.video_vs    = vs_q;
    assign vid.video_de    = de_q;
    assign vid.frame_start = fs_q;
    assign vid.video_rgb   = de_q ? vid.pixel_data : '0;

endmodule

// File: tb/tb_video_driver.sv
// Self-checking bench for video_driver: three instances (default 720p, tiny
// active-low, medium) compared each cycle against a position-arithmetic model.
module tb_video_driver;

    typedef struct {
        int hs, hb, hd, hf;
        int vs, vb, vd, vf;
        bit pol;
    } tim_t;

    tim_t TA = '{40, 220, 1280, 110, 5, 20, 720, 5, 1'b1};
    tim_t TB = '{2, 3, 8, 1, 1, 2, 4, 1, 1'b0};
    tim_t TC = '{4, 6, 20, 5, 2, 3, 10, 2, 1'b1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc;
    int   n_checks = 0;
    int   n_fail = 0;

    video_driver_if vif_a ();
    video_driver_if vif_b ();
    video_driver_if vif_c ();

    video_driver dut_a (.pixel_clk(clk), .sys_rst_n(rst_n), .vid(vif_a));

    video_driver #(
        .H_SYNC(11'd2), .H_BACK(11'd3), .H_DISP(11'd8), .H_FRONT(11'd1),
        .V_SYNC(11'd1), .V_BACK(11'd2), .V_DISP(11'd4), .V_FRONT(11'd1),
        .SYNC_POL(1'b0)
    ) dut_b (.pixel_clk(clk), .sys_rst_n(rst_n), .vid(vif_b));

    video_driver #(
        .H_SYNC(11'd4), .H_BACK(11'd6), .H_DISP(11'd20), .H_FRONT(11'd5),
        .V_SYNC(11'd2), .V_BACK(11'd3), .V_DISP(11'd10), .V_FRONT(11'd2),
        .SYNC_POL(1'b1)
    ) dut_c (.pixel_clk(clk), .sys_rst_n(rst_n), .vid(vif_c));

    always #5 clk = ~clk;

    // Cycles elapsed since reset release: the model's only notion of time.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Drawing stage: registered coordinate-derived colour, garbage when not requested.
    always @(posedge clk) begin
        vif_a.pixel_data <= vif_a.data_req ? {vif_a.pixel_xpos[7:0], vif_a.pixel_ypos[7:0], 8'hA5}
                          : ($urandom_range(0, 1) == 1 ? 24'hFFFFFF : 24'($urandom));
        vif_b.pixel_data <= vif_b.data_req ? {vif_b.pixel_xpos[7:0], vif_b.pixel_ypos[7:0], 8'hA5}
                          : ($urandom_range(0, 1) == 1 ? 24'hFFFFFF : 24'($urandom));
        vif_c.pixel_data <= vif_c.data_req ? {vif_c.pixel_xpos[7:0], vif_c.pixel_ypos[7:0], 8'hA5}
                          : ($urandom_range(0, 1) == 1 ? 24'hFFFFFF : 24'($urandom));
    end

    function automatic bit visible(tim_t t, int h, int v);
        return (h >= t.hs + t.hb) && (h < t.hs + t.hb + t.hd) &&
               (v >= t.vs + t.vb) && (v < t.vs + t.vb + t.vd);
    endfunction

    // Expected {req, xpos, ypos, hs, vs, de, frame_start, rgb} after c cycles.
    function automatic logic [50:0] model(tim_t t, int c);
        int ht, vt, h, v, hp, vp;
        bit req, hs, vs, de, fs;
        logic [10:0] x, y, xp, yp;
        logic [23:0] rgb;
        ht  = t.hs + t.hb + t.hd + t.hf;
        vt  = t.vs + t.vb + t.vd + t.vf;
        h   = c % ht;
        v   = (c / ht) % vt;
        req = visible(t, h, v);
        x   = req ? 11'(h - (t.hs + t.hb)) : 11'd0;
        y   = req ? 11'(v - (t.vs + t.vb)) : 11'd0;
        if (c == 0) begin
            hs = !t.pol; vs = !t.pol; de = 1'b0; fs = 1'b0; rgb = 24'h0;
        end else begin
            hp  = (c - 1) % ht;
            vp  = ((c - 1) / ht) % vt;
            hs  = (hp < t.hs) ? t.pol : !t.pol;
            vs  = (vp < t.vs) ? t.pol : !t.pol;
            de  = visible(t, hp, vp);
            fs  = (hp == 0) && (vp == 0);
            xp  = 11'(hp - (t.hs + t.hb));
            yp  = 11'(vp - (t.vs + t.vb));
            rgb = de ? {xp[7:0], yp[7:0], 8'hA5} : 24'h0;
        end
        return {req, x, y, hs, vs, de, fs, rgb};
    endfunction

    task automatic test_reset();
        logic [50:0] got, want;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        got = {vif_a.data_req, vif_a.pixel_xpos, vif_a.pixel_ypos, vif_a.video_hs, vif_a.video_vs,
               vif_a.video_de, vif_a.frame_start, vif_a.video_rgb};
        want = model(TA, 0);
        n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL reset_a got %h want %h", got, want); end
        got = {vif_b.data_req, vif_b.pixel_xpos, vif_b.pixel_ypos, vif_b.video_hs, vif_b.video_vs,
               vif_b.video_de, vif_b.frame_start, vif_b.video_rgb};
        want = model(TB, 0);
        n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL reset_b got %h want %h", got, want); end
        got = {vif_c.data_req, vif_c.pixel_xpos, vif_c.pixel_ypos, vif_c.video_hs, vif_c.video_vs,
               vif_c.video_de, vif_c.frame_start, vif_c.video_rgb};
        want = model(TC, 0);
        n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL reset_c got %h want %h", got, want); end
        #2 rst_n = 1'b1;
    endtask

    // 27 lines reach the first two visible lines of the 720p frame.
    task automatic test_default_lines();
        logic [50:0] got, want;
        int hs_cnt = 0, fs_cnt = 0, de_cnt = 0;
        for (int i = 0; i < 27 * 1650; i++) begin
            @(negedge clk);
            got = {vif_a.data_req, vif_a.pixel_xpos, vif_a.pixel_ypos, vif_a.video_hs, vif_a.video_vs,
                   vif_a.video_de, vif_a.frame_start, vif_a.video_rgb};
            want = model(TA, cyc);
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL a_cycle c=%0d got %h want %h", cyc, got, want); end
            if (cyc <= 3300 && vif_a.video_hs === 1'b1) hs_cnt++;
            if (vif_a.frame_start === 1'b1) fs_cnt++;
            if (vif_a.video_de === 1'b1) de_cnt++;
        end
        n_checks++;
        if (hs_cnt !== 80) begin n_fail++; $display("FAIL a_hs_2lines got %0d want 80", hs_cnt); end
        n_checks++;
        if (fs_cnt !== 1) begin n_fail++; $display("FAIL a_frame_start got %0d want 1", fs_cnt); end
        n_checks++;
        if (de_cnt !== 2560) begin n_fail++; $display("FAIL a_de_count got %0d want 2560", de_cnt); end
    endtask

    task automatic test_mid_reset();
        logic [50:0] got, want;
        int hs_cnt = 0, fs_cnt = 0;
        for (int i = 0; i < 2000 && (cyc % 1650) != 700; i++) begin
            @(negedge clk);
            got = {vif_a.data_req, vif_a.pixel_xpos, vif_a.pixel_ypos, vif_a.video_hs, vif_a.video_vs,
                   vif_a.video_de, vif_a.frame_start, vif_a.video_rgb};
            want = model(TA, cyc);
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL a_pre_rst c=%0d got %h want %h", cyc, got, want); end
        end
        n_checks++;
        if ((cyc % 1650) != 700) begin n_fail++; $display("FAIL mid_line_wait got h=%0d want 700", cyc % 1650); end
        #2 rst_n = 1'b0;
        #1;
        got = {vif_a.data_req, vif_a.pixel_xpos, vif_a.pixel_ypos, vif_a.video_hs, vif_a.video_vs,
               vif_a.video_de, vif_a.frame_start, vif_a.video_rgb};
        want = model(TA, 0);
        n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL a_async_rst got %h want %h", got, want); end
        repeat (3) begin
            @(negedge clk);
            got = {vif_a.data_req, vif_a.pixel_xpos, vif_a.pixel_ypos, vif_a.video_hs, vif_a.video_vs,
                   vif_a.video_de, vif_a.frame_start, vif_a.video_rgb};
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL a_rst_hold got %h want %h", got, want); end
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 2 * 1650; i++) begin
            @(negedge clk);
            got = {vif_a.data_req, vif_a.pixel_xpos, vif_a.pixel_ypos, vif_a.video_hs, vif_a.video_vs,
                   vif_a.video_de, vif_a.frame_start, vif_a.video_rgb};
            want = model(TA, cyc);
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL a_restart c=%0d got %h want %h", cyc, got, want); end
            if (vif_a.video_hs === 1'b1) hs_cnt++;
            if (vif_a.frame_start === 1'b1) fs_cnt++;
        end
        n_checks++;
        if (hs_cnt !== 80) begin n_fail++; $display("FAIL a_restart_hs got %0d want 80", hs_cnt); end
        n_checks++;
        if (fs_cnt !== 1) begin n_fail++; $display("FAIL a_restart_fs got %0d want 1", fs_cnt); end
    endtask

    task automatic test_small_frames();
        logic [50:0] got, want;
        int b_de = 0, b_hs = 0, b_vs = 0, b_fs = 0, c_de = 0, c_vs = 0, c_fs = 0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3 * 595; i++) begin
            @(negedge clk);
            got = {vif_b.data_req, vif_b.pixel_xpos, vif_b.pixel_ypos, vif_b.video_hs, vif_b.video_vs,
                   vif_b.video_de, vif_b.frame_start, vif_b.video_rgb};
            want = model(TB, cyc);
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL b_cycle c=%0d got %h want %h", cyc, got, want); end
            got = {vif_c.data_req, vif_c.pixel_xpos, vif_c.pixel_ypos, vif_c.video_hs, vif_c.video_vs,
                   vif_c.video_de, vif_c.frame_start, vif_c.video_rgb};
            want = model(TC, cyc);
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL c_cycle c=%0d got %h want %h", cyc, got, want); end
            if (cyc <= 112 && vif_b.video_de === 1'b1) b_de++;
            if (cyc <= 14 && vif_b.video_hs === 1'b0) b_hs++;
            if (cyc <= 112 && vif_b.video_vs === 1'b0) b_vs++;
            if (vif_b.frame_start === 1'b1) b_fs++;
            if (cyc <= 595 && vif_c.video_de === 1'b1) c_de++;
            if (cyc <= 595 && vif_c.video_vs === 1'b1) c_vs++;
            if (vif_c.frame_start === 1'b1) c_fs++;
        end
        n_checks++;
        if (b_de !== 32) begin n_fail++; $display("FAIL b_de_frame got %0d want 32", b_de); end
        n_checks++;
        if (b_hs !== 2) begin n_fail++; $display("FAIL b_hs_line got %0d want 2", b_hs); end
        n_checks++;
        if (b_vs !== 14) begin n_fail++; $display("FAIL b_vs_frame got %0d want 14", b_vs); end
        n_checks++;
        if (b_fs !== 16) begin n_fail++; $display("FAIL b_frame_starts got %0d want 16", b_fs); end
        n_checks++;
        if (c_de !== 200) begin n_fail++; $display("FAIL c_de_frame got %0d want 200", c_de); end
        n_checks++;
        if (c_vs !== 70) begin n_fail++; $display("FAIL c_vs_frame got %0d want 70", c_vs); end
        n_checks++;
        if (c_fs !== 3) begin n_fail++; $display("FAIL c_frame_starts got %0d want 3", c_fs); end
    endtask

    initial begin
        test_reset();
        test_default_lines();
        test_mid_reset();
        test_small_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_driver.md
Name: video_driver

Overview:
- Video timing generator that sits directly upstream and downstream of the display/drawing stage.
- Produces the horizontal and vertical counters and exports the current active-area coordinate (pixel_xpos/pixel_ypos) to the drawing stage.
- Takes back the 24-bit pixel_data, which the drawing stage registers with one cycle of latency.
- Drives the aligned sync, data-enable and RGB signals to the HDMI/VGA encoder. Default timing is 1280x720 @ 60 Hz (CEA-861, 74.25 MHz pixel clock).

Parameters:
H_SYNC, 11'd40, horizontal sync width (pixels)
H_BACK, 11'd220, horizontal back porch
H_DISP, 11'd1280, horizontal active pixels
H_FRONT, 11'd110, horizontal front porch
V_SYNC, 11'd5, vertical sync width (lines)
V_BACK, 11'd20, vertical back porch
V_DISP, 11'd720, vertical active lines
V_FRONT, 11'd5, vertical front porch
SYNC_POL, 1'b1, active level of video_hs/video_vs (1 = active-high)

Ports:
pixel_clk  input  1  pixel clock
sys_rst_n  input  1  reset
pixel_data  input  24  RGB from drawing stage, valid one cycle after the coordinate it belongs to
pixel_xpos  output  11  active-area column of the pixel being requested
pixel_ypos  output  11  active-area row of the pixel being requested
data_req  output  1  high while pixel_xpos/pixel_ypos address a visible pixel
video_hs  output  1  horizontal sync
video_vs  output  1  vertical sync
video_de  output  1  data enable, aligned to video_rgb
video_rgb  output  24  pixel output to encoder
frame_start  output  1  one-cycle pulse at first cycle of each frame (aligned with outputs)

Behaviour:
- Interface: one clock, pixel_clk; reset sys_rst_n is asynchronous and active-low.
- Derived constants: H_TOTAL = sum of the H_* parameters (1650), V_TOTAL = sum of the V_* parameters (750), H_ACT = H_SYNC+H_BACK (260), V_ACT = V_SYNC+V_BACK (25). Arithmetic is 11-bit unsigned; the parameter sums must be <= 2047.
- h_cnt: 0..H_TOTAL-1, increments every cycle and wraps to 0 after H_TOTAL-1.
- v_cnt: 0..V_TOTAL-1, increments only on the cycle h_cnt = H_TOTAL-1 and wraps to 0 after V_TOTAL-1 (simultaneous h and v wrap gives h_cnt = v_cnt = 0).
- data_req (combinational from counters) = (H_ACT <= h_cnt < H_ACT+H_DISP) && (V_ACT <= v_cnt < V_ACT+V_DISP).
- pixel_xpos = data_req ? h_cnt-H_ACT : 0.
- pixel_ypos = data_req ? v_cnt-V_ACT : 0.
- Request-side signals are combinational from the counters.
- Output stage: registers, updated every cycle.
  - video_hs <= (h_cnt < H_SYNC) ? SYNC_POL : ~SYNC_POL.
  - video_vs <= (v_cnt < V_SYNC) ? SYNC_POL : ~SYNC_POL. The vertical transition therefore coincides with the hs leading edge.
  - video_de <= data_req.
  - frame_start <= (h_cnt==0 && v_cnt==0).
- One-cycle delay matches the drawing stage's registered pixel_data, so video_de, video_hs, video_vs and pixel_data are mutually aligned.
- video_rgb = video_de ? pixel_data : 24'h000000 (combinational). Blanking is always black regardless of pixel_data.
- Reset values (immediate, asynchronous):
  - h_cnt = v_cnt = 0.
  - video_hs = video_vs = ~SYNC_POL.
  - video_de = 0, frame_start = 0.
  - video_rgb, data_req, pixel_xpos and pixel_ypos therefore all equal 0.
- Reset mid-frame: outputs go inactive immediately, with no partial line completed. After release, the first cycle has h_cnt = 0, v_cnt = 0, and frame_start pulses on the following cycle.
- No handshake back-pressure: the drawing stage must return pixel_data exactly one cycle after each data_req.

Test Plan:
- Release reset, run 2 lines -> video_hs active for exactly 40 cycles every 1650 cycles; first hs active cycle is the cycle after release; frame_start pulses once at that same cycle.
- Run 1 full frame -> video_vs active exactly 5*1650 = 8250 cycles, period 1,237,500 cycles; vs edges coincide with hs leading edges; frame_start once per frame.
- Count video_de -> 1280 consecutive cycles per active line, 720 active lines per frame; de rises 260 cycles after hs leading edge and 25 lines after vs leading edge.
- Monitor request side -> pixel_xpos 0 at h_cnt = 260 and 1279 at h_cnt = 1539; pixel_ypos 0 at v_cnt = 25 and 719 at v_cnt = 744; both 0 and data_req 0 elsewhere.
- Model drawing stage as pixel_data <= {xpos[7:0], ypos[7:0], 8'hA5} registered -> every de cycle video_rgb matches the coordinate requested one cycle earlier; video_rgb = 0 whenever de = 0, even with pixel_data = 24'hFFFFFF.
- Assert sys_rst_n low mid-line (h_cnt = 700, v_cnt = 300) for 3 cycles -> hs/vs/de/rgb inactive in the same cycle; after release, the timing restarts from h_cnt = v_cnt = 0.
- Repeat the first test with small parameters (H: 2/3/8/1, V: 1/2/4/1, SYNC_POL = 0) -> active-low syncs; 8 de cycles per line, 4 lines per frame.
